// File: rtl/stim_pkg.sv
// stim_pkg: default widths and loader FSM state encoding shared by the loader files
package stim_pkg;
    localparam int WORD_W_DEF = 20;
    localparam int NIB_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int NIBS_DEF   = WORD_W_DEF / NIB_W_DEF;
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
endpackage

// File: rtl/stim_fifo2.sv
// stim_fifo2: two-entry synchronous word FIFO; head reads as zero when empty
module stim_fifo2 #(
    parameter int W = stim_pkg::WORD_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/stim_word_loader.sv
// stim_word_loader: packs an LSB-first nibble stream into words, buffers two of them,
// counts pushed words and pulses err_short when a frame ends mid-word
module stim_word_loader
    import stim_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NIB_W  = NIB_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_nib,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [CNT_W-1:0]  word_count,
    output logic              err_short
);
    localparam int NIBS = WORD_W / NIB_W;
    localparam int CW = $clog2(NIBS);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBS - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [CW-1:0]            nib_cnt;
    logic [WORD_W-NIB_W-1:0]  asm_word;
    logic                     last_nib;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;

    // in_ready depends only on registered state, so a pop frees the input a cycle later
    assign last_nib  = nib_cnt == LAST_NIB;
    assign in_ready  = !(last_nib && fifo_full);
    assign accept    = in_valid && in_ready;
    assign push      = accept && last_nib;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept && !in_last ? FILL : IDLE;
            FILL:    state_nx = last_nib && fifo_full ? HOLD :
                                accept && (last_nib || in_last) ? IDLE : FILL;
            HOLD:    state_nx = fifo_full ? HOLD : FILL;
            default: state_nx = IDLE;
        endcase
    end

    // Lower nibbles shift in from the top so the first nibble ends up at bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            asm_word   <= '0;
            word_count <= '0;
            err_short  <= 1'b0;
        end else begin
            state     <= state_nx;
            err_short <= accept && in_last && !last_nib;
            if (push)
                word_count <= word_count + 1'b1;
            if (accept) begin
                nib_cnt  <= last_nib || in_last ? '0 : nib_cnt + 1'b1;
                asm_word <= {in_nib, asm_word[WORD_W-NIB_W-1:NIB_W]};
            end
        end
    end

    stim_fifo2 #(.W(WORD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({in_nib, asm_word}),
        .dout  (out_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_stim_word_loader.sv
// tb_stim_word_loader: directed checks of word assembly, buffering, short frames,
// async reset, counter wrap (narrow-counter instance) and full-rate streaming
module tb_stim_word_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_nib = 4'h0;
    logic        in_ready, out_valid, err_short;
    logic [19:0] out_word;
    logic [15:0] word_count;
    logic        w_in_ready, w_out_valid, w_err_short;
    logic [19:0] w_out_word;
    logic [3:0]  w_word_count;
    logic [19:0] w;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stim_word_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_nib(in_nib), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .word_count(word_count), .err_short(err_short)
    );

    stim_word_loader #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_nib(in_nib), .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_word(w_out_word), .word_count(w_word_count), .err_short(w_err_short)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] nib, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_nib   = nib;
        in_last  = last;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [19:0] word, input logic last);
        for (int k = 0; k < 5; k++)
            send(word[4*k +: 4], last && k == 4);
    endtask

    initial begin
        step(2);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_err_short", 32'(err_short), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: single word, consumer ready
        out_ready = 1'b1;
        send(4'h5, 1'b0);
        send(4'hA, 1'b0);
        send(4'h3, 1'b0);
        send(4'hC, 1'b0);
        chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
        send(4'hF, 1'b1);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_word", 32'(out_word), 32'h000FC3A5);
        chk("t1_word_count", 32'(word_count), 32'd1);
        step();
        chk("t1_popped", 32'(out_valid), 32'd0);

        // T2: consumer stalled, FIFO fills, back-pressure on last nibble of word 3
        out_ready = 1'b0;
        send_word(20'h12345, 1'b1);
        send_word(20'h6789A, 1'b1);
        send(4'hF, 1'b0);
        send(4'hE, 1'b0);
        send(4'hD, 1'b0);
        send(4'hC, 1'b0);
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        chk("t2_count_full", 32'(word_count), 32'd3);
        chk("t2_head", 32'(out_word), 32'h00012345);
        in_valid = 1'b1;
        in_nib   = 4'hB;
        in_last  = 1'b1;
        step(3);
        chk("t2_still_held", 32'(in_ready), 32'd0);
        chk("t2_count_held", 32'(word_count), 32'd3);
        out_ready = 1'b1;
        step();
        chk("t2_ready_after_pop", 32'(in_ready), 32'd1);
        chk("t2_head_advanced", 32'(out_word), 32'h0006789A);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t2_count_final", 32'(word_count), 32'd4);
        chk("t2_head_kept", 32'(out_word), 32'h0006789A);
        out_ready = 1'b1;
        step();
        chk("t2_word3", 32'(out_word), 32'h000BCDEF);
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // T3: frame truncated on third nibble
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b1);
        chk("t3_err_short", 32'(err_short), 32'd1);
        chk("t3_no_valid", 32'(out_valid), 32'd0);
        chk("t3_count_same", 32'(word_count), 32'd4);
        step();
        chk("t3_err_pulse", 32'(err_short), 32'd0);
        send_word(20'h34567, 1'b1);
        chk("t3_recover_valid", 32'(out_valid), 32'd1);
        chk("t3_recover_word", 32'(out_word), 32'h00034567);
        chk("t3_count", 32'(word_count), 32'd5);
        step();

        // T4: short frame while full, then async reset mid-word with FIFO full
        out_ready = 1'b0;
        send_word(20'h11111, 1'b1);
        send_word(20'h22222, 1'b1);
        chk("t4_count", 32'(word_count), 32'd7);
        chk("t4_ready_full", 32'(in_ready), 32'd1);
        send(4'h9, 1'b1);
        chk("t4_err_full", 32'(err_short), 32'd1);
        chk("t4_count_held", 32'(word_count), 32'd7);
        chk("t4_head", 32'(out_word), 32'h00011111);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_out_word", 32'(out_word), 32'd0);
        chk("t4_word_count", 32'(word_count), 32'd0);
        chk("t4_err_short", 32'(err_short), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t4_after_valid", 32'(out_valid), 32'd0);
        chk("t4_w_count", 32'(w_word_count), 32'd0);

        // T6 (+T5 on the 4-bit counter instance): back-to-back words, wrap at 16
        out_ready = 1'b1;
        start = cyc;
        for (int i = 1; i <= 16; i++) begin
            w = 20'h13579 + 20'(i) * 20'h01111;
            send_word(w, 1'b1);
            chk("t6_valid", 32'(out_valid), 32'd1);
            chk("t6_word", 32'(out_word), 32'(w));
            chk("t6_count", 32'(word_count), 32'(i));
            chk("t5_wrap_count", 32'(w_word_count), 32'(i % 16));
        end
        chk("t6_no_bubble", 32'(cyc - start), 32'd80);
        step();
        chk("t6_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
